// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for seq_restoring_divider
// Contents: FSM state enum, default operand width, counter-width helper clog2().
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W_DEFAULT = 8;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int res = 0;
        int v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - combinational W+1-bit trial subtract for one divider step
// Ports:
//   partial  in  W+1  shifted partial remainder R'
//   divisor  in  W    divisor
//   diff     out W+1  T = R' - {0,divisor}, formed as R' + ~{0,divisor} + 1
//   non_neg  out 1    T >= 0 (subtraction succeeded, quotient bit = 1)
module div_sub_step #(
    parameter int W = 8
) (
    input  logic [W:0]   partial,
    input  logic [W-1:0] divisor,
    output logic [W:0]   diff,
    output logic         non_neg
);

    localparam logic [W:0] CARRY_IN = {{W{1'b0}}, 1'b1};

    // Same structure as the adder datapath: invert the subtrahend, carry in 1.
    assign diff    = partial + {1'b1, ~divisor} + CARRY_IN;
    assign non_neg = ~diff[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional feature: define DIV_SIGNED_EN for two's-complement operands
// (truncating division, remainder takes the dividend's sign).
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_valid, o_ready        operand handshake (i_dividend, i_divisor)
//   o_valid, i_ready        result handshake (o_quotient, o_remainder, o_div_by_zero)
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int              CNT_W    = (clog2(W) < 1) ? 1 : clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t state_q;
    div_state_t state_d;

    // shift_q holds the dividend at accept; each step shifts its msb into the
    // remainder and shifts the new quotient bit in at the lsb, so after W
    // steps it holds the quotient.
    logic [W-1:0]     shift_q;
    logic [W-1:0]     divisor_q;
    // The held remainder always fits W bits (it is < divisor, or equals a
    // prefix of the dividend when dividing by zero); only R' needs W+1.
    logic [W-1:0]     rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;

    logic             accept;
    logic             last_step;
    logic [W:0]       partial;
    logic [W:0]       diff;
    logic             non_neg;
    logic [W-1:0]     rem_next;
    logic [W-1:0]     quo_next;
    logic [W-1:0]     quo_final;
    logic [W-1:0]     rem_final;
    logic [W-1:0]     dividend_in;
    logic [W-1:0]     divisor_in;

    assign accept    = i_valid && o_ready;
    assign last_step = (state_q == CALC) && (cnt_q == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // o_ready only in IDLE, so the cycle of the output handshake can never
    // also accept new operands.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE:    o_ready = 1'b1;
            DONE:    o_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- one restoring step ----------------
    assign partial = {rem_q, shift_q[W-1]};

    div_sub_step #(.W(W)) u_sub_step (
        .partial (partial),
        .divisor (divisor_q),
        .diff    (diff),
        .non_neg (non_neg)
    );

    assign rem_next = non_neg ? diff[W-1:0] : partial[W-1:0];
    assign quo_next = {shift_q[W-2:0], non_neg};

`ifdef DIV_SIGNED_EN
    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    logic dividend_neg;
    logic divisor_neg;
    logic dividend_neg_q;
    logic divisor_neg_q;

    assign dividend_neg = i_dividend[W-1];
    assign divisor_neg  = i_divisor[W-1];
    // Magnitude of -2^(W-1) is 2^(W-1), which still fits as unsigned W bits.
    assign dividend_in  = dividend_neg ? (~i_dividend + ONE_W) : i_dividend;
    assign divisor_in   = divisor_neg  ? (~i_divisor  + ONE_W) : i_divisor;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dividend_neg_q <= 1'b0;
            divisor_neg_q  <= 1'b0;
        end else if (accept) begin
            dividend_neg_q <= dividend_neg;
            divisor_neg_q  <= divisor_neg;
        end
    end

    // Sign fix-up on the last step so it lands in the output registers on
    // entry to DONE. Divide by zero forces an all-ones quotient whatever the
    // signs; the remainder fix-up restores the original dividend.
    always_comb begin
        quo_final = quo_next;
        rem_final = rem_next;
        if (dbz_q) begin
            quo_final = '1;
        end else if (dividend_neg_q ^ divisor_neg_q) begin
            quo_final = ~quo_next + ONE_W;
        end
        if (dividend_neg_q) begin
            rem_final = ~rem_next + ONE_W;
        end
    end
`else
    assign dividend_in = i_dividend;
    assign divisor_in  = i_divisor;
    assign quo_final   = quo_next;
    assign rem_final   = rem_next;
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q       <= '0;
            divisor_q     <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            dbz_q         <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                shift_q   <= dividend_in;
                divisor_q <= divisor_in;
                rem_q     <= '0;
                cnt_q     <= CNT_LAST;
                dbz_q     <= (i_divisor == '0);
            end else if (state_q == CALC) begin
                shift_q <= quo_next;
                rem_q   <= rem_next;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_ONE;
                end
            end

            // Results only change on entry to DONE and hold until the next one.
            if (last_step) begin
                o_quotient    <= quo_final;
                o_remainder   <= rem_final;
                o_div_by_zero <= dbz_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    always #5 clk = ~clk;

    seq_restoring_divider #(.W(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } result_t;

    result_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        result_t res;
        res.dbz = (b == '0);
        if (b == '0) begin
            res.q = '1;
            res.r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa;
            int sd;
            sa = $signed(a);
            sd = $signed(b);
            res.q = W'(sa / sd);
            res.r = W'(sa % sd);
`else
            res.q = a / b;
            res.r = a % b;
`endif
        end
        return res;
    endfunction

    // Present operands for one cycle; returns at the negedge of cycle 1.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", o_ready, 1);
        i_valid    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int lat = 1;
        check({tag, "_calc_ready"}, o_ready, 0);
        check({tag, "_calc_valid"}, o_valid, 0);
        while (!o_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, W + 1);
    endtask

    task automatic check_outputs(input string tag, input result_t e);
        check({tag, "_q"}, o_quotient, e.q);
        check({tag, "_r"}, o_remainder, e.r);
        check({tag, "_dbz"}, o_div_by_zero, e.dbz);
    endtask

    task automatic pop_and_check(input string tag);
        result_t e;
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic release_result(input string tag);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check({tag, "_idle_valid"}, o_valid, 0);
        check({tag, "_idle_ready"}, o_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(a, b);
        wait_valid(tag);
        pop_and_check(tag);
        release_result(tag);
    endtask

    initial begin
        result_t hold;

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_q", o_quotient, 0);
        check("rst_r", o_remainder, 0);
        check("rst_dbz", o_div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed operations
        run_op("d100_7", 8'd100, 8'd7);
        run_op("d255_1", 8'd255, 8'd1);
        run_op("d3_200", 8'd3, 8'd200);
        run_op("d5_0", 8'd5, 8'd0);
        run_op("d0_9", 8'd0, 8'd9);
        run_op("d255_255", 8'd255, 8'd255);

        // Backpressure: result held for 5 cycles, i_valid pulses ignored
        start_op(8'd77, 8'd5);
        wait_valid("bp");
        hold = sb[0];
        check_outputs("bp_first", hold);
        for (int k = 0; k < 5; k++) begin
            i_valid    = k[0];
            i_dividend = 8'd200;
            i_divisor  = 8'd3;
            @(negedge clk);
            check("bp_valid", o_valid, 1);
            check("bp_ready", o_ready, 0);
            check_outputs("bp_hold", hold);
        end
        i_valid = 1'b0;
        pop_and_check("bp_last");
        release_result("bp");
        @(negedge clk);
        check("bp_not_captured", o_ready, 1);

        // Reset in the middle of CALC
        start_op(8'd200, 8'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", o_ready, 1);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_q", o_quotient, 0);
        check("mid_rst_r", o_remainder, 0);
        check("mid_rst_dbz", o_div_by_zero, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("d9_3", 8'd9, 8'd3);

`ifdef DIV_SIGNED_EN
        run_op("s_m7_2", 8'hF9, 8'd2);
        run_op("s_m128_m1", 8'h80, 8'hFF);
        run_op("s_7_m2", 8'd7, 8'hFE);
        run_op("s_m5_0", 8'hFB, 8'd0);
`endif

        // Random operands
        for (int k = 0; k < 6; k++) begin
            run_op("rnd", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
